// File: rtl/match_unit.sv
// match_unit: multi-cycle pattern matcher, LANES offsets per cycle.
// Ports: clk, rst, start, mode, src1, src2, flush -> ready, busy, done,
//   result, found. mode 0 = lowest match offset, 1 = match count.
module match_unit #(
  parameter int DATA_W = 32,
  parameter int PAT_W  = 8,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              flush,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              found
);

  localparam int N  = DATA_W - PAT_W + 1;
  localparam int G  = (N + LANES - 1) / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t            state_q;
  logic [GW-1:0]     grp_q;
  logic [CW-1:0]     cnt_q;
  logic [PAT_W-1:0]  pat_q;
  logic [DATA_W-1:0] src_q;
  logic              mode_q;
  logic [DATA_W-1:0] result_q;
  logic              found_q;

  logic [LANES-1:0]  hit;
  logic [CW-1:0]     pop;
  logic [CW-1:0]     cnt_d;
  logic [DATA_W-1:0] win;
  logic              last_grp;
  logic              accept;
  int                off;
  int                foff;

  generate
    if (PAT_W < DATA_W) begin : g_unused
      logic unused_src1;
      assign unused_src1 = ^src1[DATA_W-1:PAT_W];
    end
  endgenerate

  // Lanes whose offset lies past N-1 stay masked (hit=0).
  always_comb begin
    hit  = '0;
    pop  = '0;
    off  = 0;
    foff = 0;
    win  = '0;
    for (int l = 0; l < LANES; l++) begin
      off = int'(grp_q) * LANES + l;
      win = src_q >> off;
      if (off < N) hit[l] = (win[PAT_W-1:0] == pat_q);
    end
    // Walk downward so the lowest hitting lane wins.
    for (int l = LANES - 1; l >= 0; l--) begin
      if (hit[l]) foff = int'(grp_q) * LANES + l;
    end
    for (int l = 0; l < LANES; l++) begin
      pop = pop + CW'(hit[l]);
    end
  end

  assign cnt_d    = cnt_q + pop;
  assign last_grp = (grp_q == GW'(G - 1));
  assign accept   = start && (state_q != SCAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grp_q    <= '0;
      cnt_q    <= '0;
      pat_q    <= '0;
      src_q    <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
      found_q  <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q <= SCAN;
            pat_q   <= src1[PAT_W-1:0];
            src_q   <= src2;
            mode_q  <= mode;
            grp_q   <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        SCAN: begin
          if (!mode_q && (|hit)) begin
            state_q  <= DONE;
            result_q <= DATA_W'(foff);
            found_q  <= 1'b1;
          end else if (last_grp) begin
            state_q <= DONE;
            if (mode_q) begin
              result_q <= DATA_W'(cnt_d);
              found_q  <= (cnt_d != '0);
            end else begin
              result_q <= DATA_W'(N);
              found_q  <= 1'b0;
            end
          end else begin
            grp_q <= grp_q + GW'(1);
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready  = (state_q != SCAN);
  assign busy   = (state_q == SCAN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign found  = found_q;

endmodule

// File: doc/match_unit.md
# match_unit

Multi-cycle, parametrised byte/field pattern matcher for the SampleCPU execute stage. Searches a DATA_W-bit source for a PAT_W-bit pattern and returns either the lowest matching bit offset or the number of matching offsets, scanning LANES offsets per cycle. Sits beside the single-cycle alu and holds the pipeline through `busy` until the result is ready.

## Interface
- DATA_W, 32: width of the searched operand and of `result`.
- PAT_W, 8: pattern width. Legal range is 1 ≤ PAT_W ≤ DATA_W.
- LANES, 1: offsets compared per cycle. Legal range is 1 ≤ LANES ≤ N, where N = DATA_W-PAT_W+1.
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset. Asynchronous and active-high.
- start  in  1  request. Accepted only when `ready`=1.
- mode  in  1  0 = FIRST (lowest matching offset), 1 = COUNT (number of matches). Sampled together with `start`.
- src1  in  DATA_W  pattern source. Only src1[PAT_W-1:0] is used.
- src2  in  DATA_W  searched operand. Sampled together with `start`.
- flush  in  1  cancel the current operation (exception or branch flush).
- ready  out  1  unit can accept `start`.
- busy  out  1  scan in progress. Used as the pipeline stall request.
- done  out  1  one-cycle pulse when `result` and `found` become valid.
- result  out  DATA_W  offset or count, zero-extended.
- found  out  1  at least one match was found.

## Operation
- Offsets: i = 0 .. N-1. A match at i means src2[i+PAT_W-1:i] == src1[PAT_W-1:0].
- Offsets are grouped as g = 0 .. G-1, with G = ceil(N/LANES). Group g covers offsets g*LANES .. g*LANES+LANES-1. Lanes with an offset ≥ N are masked off.
- States:
  - IDLE → SCAN on an accepted start. The edge latches src1[PAT_W-1:0], src2 and mode, and clears the group counter and the match count.
  - SCAN evaluates one group per cycle.
  - SCAN → DONE:
    - FIRST mode: on the first group that contains a match. `result` = the lowest matching offset in that group, `found`=1.
    - COUNT mode: after group G-1. `result` = the accumulated count, `found` = (count≠0).
    - Either mode: after group G-1 with no match. FIRST gives `result` = N, `found`=0.
  - DONE → IDLE unconditionally, or → SCAN if `start` is accepted in DONE.
- `ready` = (state≠SCAN). `busy` = (state==SCAN). `done` = (state==DONE).
- `start` while busy is ignored. The latched operands are unaffected.
- `result`/`found` hold their value from DONE until the next DONE. They are not cleared by a new start or by flush.
- Count accumulator width is clog2(N+1) bits, zero-extended into `result`. It cannot overflow.
- flush:
  - Forces IDLE on the next edge from any state. No `done` is produced for the cancelled operation.
  - flush and start in the same cycle: flush wins and start is dropped.
  - flush in DONE suppresses nothing: the pulse in that cycle has already occurred.
- rst:
  - Asserting rst at any time immediately forces IDLE.
  - Reset values: ready=1, busy=0, done=0, result=0, found=0, count=0, group counter=0.

## Timing
- Start is accepted at edge E0. Group g is evaluated during the cycle after edge E(g) and registered at edge E(g+1).
- `done` is high for exactly one cycle, following edge E(t+1), where t is the terminating group.
- FIRST latency with a match at offset i: floor(i/LANES)+1 cycles from the accepting edge to `done`.
- FIRST latency with no match, and COUNT latency in all cases: G cycles.
- Back-to-back operation: start in the DONE cycle is accepted. This gives one op per (latency+1) cycles with no idle bubble.
- `busy` rises the cycle after the accepting edge and falls in the same cycle that `done` rises.
- No combinational path from inputs to outputs.

## Test plan
All scenarios use DATA_W=32, PAT_W=8, LANES=1 (N=25, G=25) unless stated otherwise.
- FIRST, src1=0x000000A5, src2=0x0000A500 → result=8, found=1, `done` 9 cycles after the accept edge. Repeating with src1=0xFFFFFFA5 gives an identical result.
- FIRST, src1=0x000000FF, src2=0x00000000 → result=25, found=0, `done` after 25 cycles.
- COUNT, src1=0x55, src2=0x55555555 → result=13 (even offsets 0..24), found=1, 25 cycles. COUNT with src1=0x00, src2=0x00000000 → result=25.
- LANES=4, FIRST on the first scenario → result=8, `done` after 3 cycles. LANES=4, COUNT with N=25 → `done` after 7 cycles, lanes past offset 24 are masked, result=13 for the 0x55 case.
- Flush at cycle 5 of a scan → busy=0 and ready=1 next cycle, no `done`, result keeps its prior value. A start two cycles later completes normally. rst asserted mid-scan → all outputs at reset values with no clock edge.
- Start held high across a whole operation → the second start is ignored while busy and accepted in the DONE cycle. Two consecutive results are produced with no extra idle cycle, each `done` exactly one cycle wide.
